// File: rtl/mandelbrot_iter_unit.sv
// mandelbrot_iter_unit
//   Escape-time engine. Accepts one complex point c per input handshake and
//   iterates z <- z^2 + c from z = 0, one iteration per clock, until
//   |z|^2 > 4.0 (escaped) or the iteration limit is reached. Returns the
//   iteration count, the escaped flag and the pass-through tag.
//
// Ports:
//   aclk          sole clock, rising edge
//   periph_reset  asynchronous, active-high reset
//   cfg_max_iter  iteration limit, sampled on the input handshake
//   in_valid      point valid
//   in_ready      unit idle and able to accept a point
//   in_c_re       real part of c, signed fixed point (FRAC fractional bits)
//   in_c_im       imaginary part of c
//   in_tag        sideband, returned unchanged on out_tag
//   out_valid     result valid
//   out_ready     downstream accepts the result
//   out_iter      iteration count
//   out_escaped   1 = |z|^2 exceeded 4.0, 0 = limit reached
//   out_tag       tag of this point
module mandelbrot_iter_unit #(
    parameter int unsigned W      = 32,
    parameter int unsigned FRAC   = 28,
    parameter int unsigned ITER_W = 10,
    parameter int unsigned TAG_W  = 2
) (
    input  logic              aclk,
    input  logic              periph_reset,
    input  logic [ITER_W-1:0] cfg_max_iter,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_c_re,
    input  logic [W-1:0]      in_c_im,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 4.0 in the widened W+4 bit domain
    localparam logic signed [W+3:0] LP_FOUR = (W+4)'(4) << FRAC;

    logic [1:0]          r_state;
    logic signed [W-1:0] r_cr;
    logic signed [W-1:0] r_ci;
    logic signed [W-1:0] r_zr;
    logic signed [W-1:0] r_zi;
    logic [ITER_W-1:0]   r_k;
    logic [ITER_W-1:0]   r_max;
    logic [TAG_W-1:0]    r_tag;
    logic [ITER_W-1:0]   r_out_iter;
    logic                r_out_escaped;

    logic signed [2*W-1:0] w_zr_sq_full;
    logic signed [2*W-1:0] w_zi_sq_full;
    logic signed [2*W-1:0] w_zrzi_full;
    logic signed [W+3:0]   w_zr_sq;
    logic signed [W+3:0]   w_zi_sq;
    logic signed [W+3:0]   w_zrzi2;
    logic signed [W+3:0]   w_cr_ext;
    logic signed [W+3:0]   w_ci_ext;
    logic signed [W+3:0]   w_mag;
    logic signed [W+3:0]   w_zr_next;
    logic signed [W+3:0]   w_zi_next;
    logic                  w_escape;

    // Full-width products, arithmetic shift truncates toward -inf
    assign w_zr_sq_full = r_zr * r_zr;
    assign w_zi_sq_full = r_zi * r_zi;
    assign w_zrzi_full  = r_zr * r_zi;
    assign w_zr_sq      = (W+4)'(w_zr_sq_full >>> FRAC);
    assign w_zi_sq      = (W+4)'(w_zi_sq_full >>> FRAC);
    // 2*zr*zi: doubling folded into the shift so no product bit is lost
    assign w_zrzi2      = (W+4)'(w_zrzi_full >>> (FRAC - 1));

    assign w_cr_ext  = {{4{r_cr[W-1]}}, r_cr};
    assign w_ci_ext  = {{4{r_ci[W-1]}}, r_ci};

    assign w_mag     = w_zr_sq + w_zi_sq;
    assign w_escape  = (w_mag > LP_FOUR);
    assign w_zr_next = w_zr_sq - w_zi_sq + w_cr_ext;
    assign w_zi_next = w_zrzi2 + w_ci_ext;

    // Clamp a W+4 bit value to the W-bit signed range
    function automatic logic [W-1:0] f_sat(input logic [W+3:0] x);
        if (x[W+3:W-1] == {5{x[W+3]}}) begin
            return x[W-1:0];
        end else if (x[W+3]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    always_ff @(posedge aclk or posedge periph_reset) begin
        if (periph_reset) begin
            r_state       <= ST_IDLE;
            r_cr          <= '0;
            r_ci          <= '0;
            r_zr          <= '0;
            r_zi          <= '0;
            r_k           <= '0;
            r_max         <= '0;
            r_tag         <= '0;
            r_out_iter    <= '0;
            r_out_escaped <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cr    <= in_c_re;
                        r_ci    <= in_c_im;
                        r_tag   <= in_tag;
                        r_max   <= cfg_max_iter;
                        r_zr    <= '0;
                        r_zi    <= '0;
                        r_k     <= '0;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (w_escape) begin
                        r_out_iter    <= r_k;
                        r_out_escaped <= 1'b1;
                        r_state       <= ST_DONE;
                    end else if (r_k == r_max) begin
                        r_out_iter    <= r_max;
                        r_out_escaped <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_zr <= f_sat(w_zr_next);
                        r_zi <= f_sat(w_zi_next);
                        r_k  <= r_k + ITER_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out_iter    = r_out_iter;
    assign out_escaped = r_out_escaped;
    assign out_tag     = r_tag;

endmodule

// File: tb/tb_mandelbrot_iter_unit.sv
module tb_mandelbrot_iter_unit;

    localparam int W      = 32;
    localparam int FRAC   = 28;
    localparam int ITER_W = 10;
    localparam int TAG_W  = 2;

    localparam int ONE    = 1 << FRAC;
    localparam int P2_5   = 671088640;   // 2.5
    localparam int N2_0   = -536870912;  // -2.0

    logic              aclk;
    logic              periph_reset;
    logic [ITER_W-1:0] cfg_max_iter;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_c_re;
    logic [W-1:0]      in_c_im;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;
    logic [TAG_W-1:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    mandelbrot_iter_unit #(
        .W      (W),
        .FRAC   (FRAC),
        .ITER_W (ITER_W),
        .TAG_W  (TAG_W)
    ) dut (
        .aclk         (aclk),
        .periph_reset (periph_reset),
        .cfg_max_iter (cfg_max_iter),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_c_re      (in_c_re),
        .in_c_im      (in_c_im),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_iter     (out_iter),
        .out_escaped  (out_escaped),
        .out_tag      (out_tag)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int         cr;
        int         ci;
        logic [1:0] tag;
        int         m;
        int         exp_iter;
        bit         exp_esc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Escape-time reference in plain integer fixed-point arithmetic
    function automatic void model(input longint cr, input longint ci, input int m,
                                  output int it, output bit esc);
        longint zr = 0;
        longint zi = 0;
        longint mag, nzr, nzi;
        longint four = longint'(4) <<< FRAC;
        longint maxv = (longint'(1) <<< (W - 1)) - 1;
        longint minv = -(longint'(1) <<< (W - 1));
        for (int k = 0; k <= 1023; k++) begin
            mag = ((zr * zr) >>> FRAC) + ((zi * zi) >>> FRAC);
            if (mag > four) begin
                it = k; esc = 1'b1; return;
            end
            if (k == m) begin
                it = m; esc = 1'b0; return;
            end
            nzr = ((zr * zr) >>> FRAC) - ((zi * zi) >>> FRAC) + cr;
            nzi = ((zr * zi) >>> (FRAC - 1)) + ci;
            zr = (nzr > maxv) ? maxv : (nzr < minv) ? minv : nzr;
            zi = (nzi > maxv) ? maxv : (nzi < minv) ? minv : nzi;
        end
        it = m; esc = 1'b0;
    endfunction

    // Present a point and complete the input handshake on the next edge
    task automatic send(input int cr, input int ci, input logic [1:0] tag, input int m);
        check("in_ready_before_send", longint'(in_ready), 1);
        in_c_re      = cr;
        in_c_im      = ci;
        in_tag       = tag;
        cfg_max_iter = ITER_W'(m);
        in_valid     = 1'b1;
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge aclk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge aclk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_pop", longint'(in_ready), 1);
        check("out_valid_after_pop", longint'(out_valid), 0);
    endtask

    task automatic run_point(input string name, input int cr, input int ci,
                             input logic [1:0] tag, input int m,
                             input int exp_iter, input bit exp_esc);
        int cyc;
        send(cr, ci, tag, m);
        wait_valid(cyc);
        check({name, "_latency"}, cyc, exp_iter + 1);
        check({name, "_iter"}, out_iter, exp_iter);
        check({name, "_escaped"}, out_escaped, exp_esc);
        check({name, "_tag"}, out_tag, tag);
        pop();
    endtask

    initial begin
        int cyc;
        int it;
        bit esc;
        int cr, ci, m;
        logic [1:0] tg;

        vecs[0] = '{cr: 0,     ci: 0,    tag: 2'b01, m: 64, exp_iter: 64, exp_esc: 1'b0};
        vecs[1] = '{cr: P2_5,  ci: 0,    tag: 2'b10, m: 64, exp_iter: 1,  exp_esc: 1'b1};
        vecs[2] = '{cr: ONE,   ci: 0,    tag: 2'b11, m: 64, exp_iter: 3,  exp_esc: 1'b1};
        vecs[3] = '{cr: N2_0,  ci: 0,    tag: 2'b00, m: 64, exp_iter: 64, exp_esc: 1'b0};
        vecs[4] = '{cr: 0,     ci: ONE,  tag: 2'b01, m: 64, exp_iter: 64, exp_esc: 1'b0};
        vecs[5] = '{cr: P2_5,  ci: 0,    tag: 2'b10, m: 0,  exp_iter: 0,  exp_esc: 1'b0};
        vecs[6] = '{cr: -ONE,  ci: 0,    tag: 2'b11, m: 64, exp_iter: 64, exp_esc: 1'b0};
        vecs[7] = '{cr: 0,     ci: P2_5, tag: 2'b01, m: 64, exp_iter: 1,  exp_esc: 1'b1};
        vecs[8] = '{cr: ONE,   ci: 0,    tag: 2'b10, m: 2,  exp_iter: 2,  exp_esc: 1'b0};

        periph_reset = 1'b1;
        cfg_max_iter = '0;
        in_valid     = 1'b0;
        in_c_re      = '0;
        in_c_im      = '0;
        in_tag       = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_iter", out_iter, 0);
        check("rst_out_escaped", out_escaped, 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge aclk);
        periph_reset = 1'b0;
        #1;

        for (int i = 0; i < 9; i++) begin
            run_point($sformatf("vec%0d", i), vecs[i].cr, vecs[i].ci, vecs[i].tag,
                      vecs[i].m, vecs[i].exp_iter, vecs[i].exp_esc);
        end

        // Backpressure: result held, pending input refused until popped
        send(ONE, 0, 2'b10, 64);
        wait_valid(cyc);
        in_c_re  = 0;
        in_c_im  = P2_5;
        in_tag   = 2'b11;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_iter", out_iter, 3);
            check("bp_escaped", out_escaped, 1);
            check("bp_tag", out_tag, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge aclk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        check("bp_pending_taken", in_ready, 0);
        wait_valid(cyc);
        check("bp_pending_latency", cyc, 2);
        check("bp_pending_iter", out_iter, 1);
        check("bp_pending_tag", out_tag, 2'b11);
        pop();

        // Reset mid-iteration aborts the point
        send(0, 0, 2'b11, 64);
        repeat (20) @(posedge aclk);
        #1;
        check("pre_rst_in_ready", in_ready, 0);
        periph_reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_iter", out_iter, 0);
        check("midrst_out_escaped", out_escaped, 0);
        check("midrst_out_tag", out_tag, 0);
        @(negedge aclk);
        periph_reset = 1'b0;
        repeat (3) begin
            @(posedge aclk);
            #1;
            check("post_rst_no_result", out_valid, 0);
        end
        run_point("after_rst", P2_5, 0, 2'b01, 64, 1, 1'b1);

        // Limit change while iterating does not affect the current point
        send(0, 0, 2'b00, 64);
        repeat (5) @(posedge aclk);
        #1;
        cfg_max_iter = ITER_W'(8);
        wait_valid(cyc);
        check("cfgchg_latency", cyc + 5, 65);
        check("cfgchg_iter", out_iter, 64);
        check("cfgchg_escaped", out_escaped, 0);
        pop();

        // Random points against the reference model
        for (int i = 0; i < 40; i++) begin
            cr = int'($urandom_range(0, 1342177280)) - P2_5;
            ci = int'($urandom_range(0, 1342177280)) - P2_5;
            m  = int'($urandom_range(0, 40));
            tg = 2'($urandom_range(0, 3));
            model(longint'(cr), longint'(ci), m, it, esc);
            run_point($sformatf("rnd%0d", i), cr, ci, tg, m, it, esc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
